// File: rtl/gf8_mul_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : gf8_mul_sched
//  Purpose  : Round-robin scheduler for two requesters sharing one 8-bit
//             truncated carry-less multiplier. It builds the 15-bit product
//             in two passes (direct, then bit-reversed) and can optionally
//             reduce the product modulo a GF(2^8) polynomial, one bit per
//             cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module gf8_mul_sched #(
   parameter logic [7:0] POLY   = 8'h1B,
   parameter bit         REDUCE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [7:0]  s0_a,
   input  logic [7:0]  s0_b,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [7:0]  s1_a,
   input  logic [7:0]  s1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_prod,
   output logic [7:0]  rsp_y,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_RED  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Reduction walks the product from its top bit down to x^8.
   localparam logic [3:0] c_idx_top  = 4'd14;
   localparam logic [3:0] c_idx_last = 4'd8;

   state_t      state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic        id_q, id_d;
   logic        last_q, last_d;
   logic [14:0] prod_q, prod_d;
   logic [14:0] r_q, r_d;
   logic [3:0]  idx_q, idx_d;

   logic [7:0]  w_core_a;
   logic [7:0]  w_core_b;
   logic [7:0]  w_core_y;
   logic [6:0]  w_hi_bits;
   logic [14:0] w_poly_sh;
   logic        w_grant1;

   // Truncated carry-less multiply: y[k] = XOR of a[i]&b[j] with i+j=k.
   function automatic logic [7:0] clmul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] y;
      y = '0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i <= k; i++) begin
            y[k] = y[k] ^ (a[i] & b[k-i]);
         end
      end
      return y;
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) y[i] = x[7-i];
      return y;
   endfunction

   function automatic logic [6:0] rev7(input logic [6:0] x);
      logic [6:0] y;
      for (int i = 0; i < 7; i++) y[i] = x[6-i];
      return y;
   endfunction

   // Shared multiplier core; operands are parked at zero outside LO/HI.
   always_comb begin
      w_core_a = '0;
      w_core_b = '0;
      if (state_q == S_LO) begin
         w_core_a = a_q;
         w_core_b = b_q;
      end else if (state_q == S_HI) begin
         w_core_a = rev8(a_q);
         w_core_b = rev8(b_q);
      end
      w_core_y  = clmul8(w_core_a, w_core_b);
      // Low byte of the reversed product is P[14:7] reversed; bit 7 repeats P[7].
      w_hi_bits = rev7(w_core_y[6:0]);
      w_poly_sh = {7'd0, POLY} << (idx_q - c_idx_last);
   end

   // Round-robin grant: a tie goes to the requester not served last.
   always_comb begin
      if (s0_valid && s1_valid) w_grant1 = ~last_q;
      else                      w_grant1 = s1_valid;
      s0_ready = rst_n && (state_q == S_IDLE) && s0_valid && !w_grant1;
      s1_ready = rst_n && (state_q == S_IDLE) && s1_valid &&  w_grant1;
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      last_d  = last_q;
      prod_d  = prod_q;
      r_d     = r_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (s0_ready) begin
               a_d     = s0_a;
               b_d     = s0_b;
               id_d    = 1'b0;
               last_d  = 1'b0;
               state_d = S_LO;
            end else if (s1_ready) begin
               a_d     = s1_a;
               b_d     = s1_b;
               id_d    = 1'b1;
               last_d  = 1'b1;
               state_d = S_LO;
            end
         end
         S_LO: begin
            prod_d[7:0] = w_core_y;
            state_d     = S_HI;
         end
         S_HI: begin
            prod_d[14:8] = w_hi_bits;
            r_d          = {w_hi_bits, prod_q[7:0]};
            idx_d        = c_idx_top;
            state_d      = REDUCE ? S_RED : S_DONE;
         end
         S_RED: begin
            // The shifted polynomial stops one bit below idx, so the leading
            // x^idx term is cleared explicitly.
            if (r_q[idx_q]) r_d = r_q ^ w_poly_sh ^ (15'd1 << idx_q);
            idx_d = idx_q - 4'd1;
            if (idx_q == c_idx_last) state_d = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         prod_q  <= '0;
         r_q     <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         last_q  <= last_d;
         prod_q  <= prod_d;
         r_q     <= r_d;
         idx_q   <= idx_d;
      end
   end

   assign rsp_valid = (state_q == S_DONE);
   assign rsp_id    = id_q;
   assign rsp_prod  = {1'b0, prod_q};
   assign rsp_y     = REDUCE ? r_q[7:0] : prod_q[7:0];
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gf8_mul_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gf8_mul_sched
//  Purpose  : Self-checking bench for gf8_mul_sched (reducing and raw
//             variants) against a long-division reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gf8_mul_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        s0_valid, s0_ready, s1_valid, s1_ready;
   logic [7:0]  s0_a, s0_b, s1_a, s1_b;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_prod;
   logic [7:0]  rsp_y;

   logic        n_valid, n_ready, n_s1_ready, n_rsp_valid, n_rsp_id, n_busy;
   logic [7:0]  n_a, n_b, n_y;
   logic [15:0] n_prod;

   int total;
   int bad;

   typedef struct {
      logic        id;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
      logic [7:0]  y;
   } vec_t;

   typedef struct {
      logic        id;
      logic [15:0] prod;
      logic [7:0]  y;
   } exp_t;

   vec_t vecs[5];
   exp_t expq[$];

   gf8_mul_sched #(.POLY(8'h1B), .REDUCE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_a(s0_a), .s0_b(s0_b),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_a(s1_a), .s1_b(s1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_prod(rsp_prod), .rsp_y(rsp_y), .busy(busy)
   );

   gf8_mul_sched #(.POLY(8'h1B), .REDUCE(1'b0)) dut_nr (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(n_valid), .s0_ready(n_ready), .s0_a(n_a), .s0_b(n_b),
      .s1_valid(1'b0), .s1_ready(n_s1_ready), .s1_a(8'h00), .s1_b(8'h00),
      .rsp_valid(n_rsp_valid), .rsp_ready(1'b1), .rsp_id(n_rsp_id),
      .rsp_prod(n_prod), .rsp_y(n_y), .busy(n_busy)
   );

   // Reference: schoolbook carry-less product.
   function automatic logic [15:0] ref_clmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      return p;
   endfunction

   // Reference: polynomial long division by x^8 + POLY.
   function automatic logic [7:0] ref_reduce(input logic [15:0] p);
      logic [15:0] r;
      r = p;
      for (int i = 14; i >= 8; i--) if (r[i]) r = r ^ (16'h011B << (i - 8));
      return r[7:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One job on the reducing instance with rsp_ready held high.
   task automatic run_one(input string tag, input logic id, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] ep, input logic [7:0] ey);
      int waitc;
      int lat;
      if (id) begin s1_valid = 1'b1; s1_a = a; s1_b = b; end
      else    begin s0_valid = 1'b1; s0_a = a; s0_b = b; end
      #1;
      waitc = 0;
      while (!(id ? s1_ready : s0_ready) && waitc < 20) begin tick(); waitc++; end
      check({tag, "_accept_wait"}, 32'(waitc), 32'd0);
      tick();
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 30) begin tick(); lat++; end
      check({tag, "_latency"}, 32'(lat), 32'd10);
      check({tag, "_prod"}, 32'(rsp_prod), 32'(ep));
      check({tag, "_y"}, 32'(rsp_y), 32'(ey));
      check({tag, "_id"}, 32'(rsp_id), 32'(id));
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int nacc, last_cyc, acc_who, lat;
      logic [7:0] pa, pb, ra, rb;
      logic [15:0] ep;
      exp_t e;

      vecs[0] = '{1'b0, 8'h57, 8'h83, 16'h2B79, 8'hC1};
      vecs[1] = '{1'b1, 8'h02, 8'h80, 16'h0100, 8'h1B};
      vecs[2] = '{1'b1, 8'h53, 8'hCA, 16'h3F7E, 8'h01};
      vecs[3] = '{1'b0, 8'h80, 8'h80, 16'h4000, 8'h9A};
      vecs[4] = '{1'b1, 8'h00, 8'hFF, 16'h0000, 8'h00};

      total = 0; bad = 0;
      rst_n = 1'b0; rsp_ready = 1'b1;
      s0_valid = 1'b1; s1_valid = 1'b1;
      s0_a = 8'h11; s0_b = 8'h22; s1_a = 8'h33; s1_b = 8'h44;
      n_valid = 1'b0; n_a = 8'h00; n_b = 8'h00;
      #2;
      // Reset state, with both valids high: readies must stay low.
      check("reset_outputs", 32'({rsp_valid, busy, rsp_id, rsp_prod, rsp_y}), 32'd0);
      check("reset_readies", 32'({s0_ready, s1_ready}), 32'd0);
      check("reset_nr_busy", 32'({n_busy, n_rsp_valid}), 32'd0);
      s0_valid = 1'b0; s1_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Directed vector table.
      foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i].id, vecs[i].a,
                                vecs[i].b, vecs[i].prod, vecs[i].y);

      // Both requesters valid from reset with random operands: alternating grants.
      rst_n = 1'b0;
      tick();
      s0_valid = 1'b1; s1_valid = 1'b1;
      s0_a = 8'($urandom); s0_b = 8'($urandom);
      s1_a = 8'($urandom); s1_b = 8'($urandom);
      rst_n = 1'b1;
      #1;
      nacc = 0; last_cyc = 0;
      for (int cyc = 0; cyc < 150 && nacc < 8; cyc++) begin
         acc_who = 0;
         if (s0_ready || s1_ready) begin
            check("alt_grant", 32'(s1_ready), 32'(nacc % 2));
            if (nacc > 0) check("alt_gap", 32'(cyc - last_cyc), 32'd11);
            last_cyc = cyc;
            pa = s1_ready ? s1_a : s0_a;
            pb = s1_ready ? s1_b : s0_b;
            e.id = s1_ready;
            e.prod = ref_clmul(pa, pb);
            e.y = ref_reduce(e.prod);
            expq.push_back(e);
            acc_who = s1_ready ? 2 : 1;
            nacc++;
         end
         if (rsp_valid) begin
            if (expq.size() == 0) check("alt_unexpected_rsp", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               check("alt_prod", 32'(rsp_prod), 32'(e.prod));
               check("alt_y", 32'(rsp_y), 32'(e.y));
               check("alt_id", 32'(rsp_id), 32'(e.id));
            end
         end
         tick();
         if (acc_who == 1) begin s0_a = 8'($urandom); s0_b = 8'($urandom); end
         if (acc_who == 2) begin s1_a = 8'($urandom); s1_b = 8'($urandom); end
      end
      check("alt_count", 32'(nacc), 32'd8);
      s0_valid = 1'b0; s1_valid = 1'b0;
      for (int k = 0; k < 20 && expq.size() > 0; k++) begin
         if (rsp_valid) begin
            e = expq.pop_front();
            check("alt_last_prod", 32'(rsp_prod), 32'(e.prod));
            check("alt_last_y", 32'(rsp_y), 32'(e.y));
         end
         tick();
      end
      check("alt_drained", 32'(expq.size()), 32'd0);

      // Back-pressure in DONE.
      rsp_ready = 1'b0;
      s0_valid = 1'b1; s0_a = 8'h02; s0_b = 8'h80;
      #1;
      check("hold_accept", 32'(s0_ready), 32'd1);
      tick();
      s0_valid = 1'b0;
      s1_valid = 1'b1; s1_a = 8'h53; s1_b = 8'hCA;
      lat = 1;
      while (!rsp_valid && lat < 30) begin tick(); lat++; end
      check("hold_latency", 32'(lat), 32'd10);
      for (int k = 0; k < 5; k++) begin
         check("hold_stable", 32'({rsp_valid, rsp_id, rsp_prod, rsp_y, s0_ready, s1_ready}),
               32'({1'b1, 1'b0, 16'h0100, 8'h1B, 1'b0, 1'b0}));
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("hold_release_valid", 32'(rsp_valid), 32'd1);
      tick();
      check("hold_idle", 32'({busy, rsp_valid, s1_ready}), 32'({1'b0, 1'b0, 1'b1}));
      tick();
      s1_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 30) begin tick(); lat++; end
      check("hold_next_latency", 32'(lat), 32'd10);
      check("hold_next_result", 32'({rsp_id, rsp_prod, rsp_y}), 32'({1'b1, 16'h3F7E, 8'h01}));
      tick();

      // Asynchronous reset while reducing (index 11).
      s0_valid = 1'b1; s0_a = 8'h57; s0_b = 8'h83;
      #1;
      check("rred_accept", 32'(s0_ready), 32'd1);
      repeat (6) tick();
      check("rred_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rred_async_clear", 32'({rsp_valid, busy, rsp_id, rsp_prod, rsp_y, s0_ready, s1_ready}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      run_one("rred_fresh", 1'b0, 8'h57, 8'h83, 16'h2B79, 8'hC1);

      // Raw-product instance: latency 3, back-to-back every 4 cycles.
      for (int j = 0; j < 5; j++) begin
         ra = (j == 0) ? 8'hFF : 8'($urandom);
         rb = (j == 0) ? 8'hFF : 8'($urandom);
         ep = (j == 0) ? 16'h5555 : ref_clmul(ra, rb);
         n_valid = 1'b1; n_a = ra; n_b = rb;
         #1;
         check("nr_accept", 32'(n_ready), 32'd1);
         tick();
         n_valid = 1'b0;
         lat = 1;
         while (!n_rsp_valid && lat < 20) begin tick(); lat++; end
         check("nr_latency", 32'(lat), 32'd3);
         check("nr_prod", 32'(n_prod), 32'(ep));
         check("nr_y", 32'(n_y), 32'(ep[7:0]));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gf8_mul_sched.md
# gf8_mul_sched

Shared-resource scheduler for the team's 8-bit truncated carry-less multiplier core (`a`, `b`, `y`: `y[k] = XOR over i+j=k of a[i]&b[j]`, k=0..7). It serves two requesters through one combinational instance using round-robin arbitration. For each job it:

- obtains the full 15-bit carry-less product in two passes through the core: low half direct, high half via bit-reversed operands;
- optionally reduces the product modulo a GF(2^8) polynomial with a 7-cycle serial reducer.

It sits between the crypto/ECC front-ends and the multiplier datapath.

## Interface
Parameters:
- `POLY`, 8'h1B, low 8 bits of the monic degree-8 reduction polynomial (x^8 implied).
- `REDUCE`, 1, 1 = perform GF(2^8) reduction; 0 = return raw product only.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s0_valid` / `s1_valid`  in  1  requester 0/1 job valid.
- `s0_ready` / `s1_ready`  out  1  requester 0/1 accept.
- `s0_a`, `s0_b`, `s1_a`, `s1_b`  in  8  operands.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  1  requester that issued the job.
- `rsp_prod`  out  16  raw carry-less product; bit 15 is always 0.
- `rsp_y`  out  8  reduced result; equals `rsp_prod[7:0]` when `REDUCE=0`.
- `busy`  out  1  state != IDLE.

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
States: IDLE, LO, HI, RED, DONE.

- **IDLE**
  - `sX_ready` = 1 only for the granted requester. Grant goes to the only valid requester, or on a tie to the one not served last.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
  - On `sX_valid & sX_ready`: latch a, b and id, set `last` = X, go to LO.
  - With no valid requester, both readies are 0.
- **LO**: core inputs are (a, b); register `P[7:0]` = y. Go to HI.
- **HI**: core inputs are (rev8(a), rev8(b)); register `P[14:8]` = rev7(y[6:0]). This holds because the reversed product's low byte is `P[14:7]` reversed.
  - Go to RED if `REDUCE=1`, else DONE.
- **RED**: 4-bit index i starts at 14 and decrements once per cycle down to 8, so RED lasts exactly 7 cycles.
  - Each cycle `R` is updated: if `R[i]` is set, then `R ^= POLY << (i-8)` and `R[i]` is cleared.
  - `R` is initialised from P on entry.
  - After i=8, go to DONE.
- **DONE**: `rsp_valid` = 1; `rsp_prod`, `rsp_y` and `rsp_id` are held stable until `rsp_ready`. On handshake go to IDLE.
- In all non-IDLE states both `sX_ready` = 0; requests wait with no loss and no reordering per requester.
- The core is never driven with operands outside LO/HI. In other states its inputs are held at 0 to limit toggling.
- All arithmetic is XOR only; no carries. `rsp_prod` is zero-extended to 16 bits.

## Timing
- Reset, and any reset assertion mid-job, aborts immediately. State = IDLE, `last` = 1, and `rsp_valid`, `rsp_id`, `rsp_prod`, `rsp_y`, `busy` = 0. Both readies are forced to 0 while `rst_n` is low.
- Accept at cycle T. With `REDUCE=1`, `rsp_valid` rises at T+10: LO T+1, HI T+2, RED T+3..T+9, DONE T+10. With `REDUCE=0`, `rsp_valid` rises at T+3.
- If `rsp_ready` is high in the first DONE cycle, the next accept is at T+11 (`REDUCE=1`) or T+4 (`REDUCE=0`).
- Peak throughput is one job per 11 cycles (`REDUCE=1`) or one job per 4 cycles (`REDUCE=0`).
- Readies are combinational from state, `last` and both valids. No combinational path runs from `rsp_ready` to any output other than via the state register.
- `rsp_ready` is ignored outside DONE.
- Requester valid dropped before acceptance: no effect and no grant.

## Test plan
- Reset, then s0: a=0x57, b=0x83, `rsp_ready`=1 → `rsp_valid` at T+10 with `rsp_prod`=0x2B79, `rsp_y`=0xC1, `rsp_id`=0.
- s1: a=0x02, b=0x80 → `rsp_prod`=0x0100, `rsp_y`=0x1B, `rsp_id`=1. Also a=0x53, b=0xCA → `rsp_y`=0x01.
- Both valid continuously from reset with distinct operands → grants alternate 0,1,0,1. Each accept is 11 cycles apart and results match a reference model.
- Hold `rsp_ready`=0 for 5 cycles in DONE → outputs stable and both readies 0. Release → handshake, then IDLE, then the next accept one cycle later.
- Assert `rst_n`=0 during RED (i=11) → outputs 0 asynchronously. After release the pending s0 job is accepted fresh with the correct result.
- `REDUCE=0`, a=0xFF, b=0xFF → `rsp_valid` at T+3 with `rsp_prod`=0x5555 and `rsp_y`=0x55.
